// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the nibble-serial adder sequencer
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the nibble index counter
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_nibble.sv
// rtl/adder_nibble.sv - combinational 4-bit adder slice with carry in/out
module adder_nibble
    import adder_pkg::*;
(
    input  logic                cin,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic                cout,
    output logic [NIBBLE_W-1:0] s
);

    logic [NIBBLE_W:0] full;

    // One extra bit captures the slice carry-out
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    end

    assign s    = full[NIBBLE_W-1:0];
    assign cout = full[NIBBLE_W];

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - wide adder reusing one nibble slice, LSB first; ADDER_SEQ_OVF_EN adds ovf output
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
`ifdef ADDER_SEQ_OVF_EN
    output logic                        ovf,
`endif
    output logic                        cout
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (clog2(NIBBLES) < 1) ? 1 : clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t               state;
    logic [W-1:0]         a_r;
    logic [W-1:0]         b_r;
    logic [IDX_W-1:0]     idx;
    logic                 carry;
    logic [NIBBLE_W-1:0]  slice_a;
    logic [NIBBLE_W-1:0]  slice_b;
    logic [NIBBLE_W-1:0]  slice_s;
    logic                 slice_co;

    assign slice_a = a_r[idx*NIBBLE_W +: NIBBLE_W];
    assign slice_b = b_r[idx*NIBBLE_W +: NIBBLE_W];

    adder_nibble u_slice (
        .cin  (carry),
        .a    (slice_a),
        .b    (slice_b),
        .cout (slice_co),
        .s    (slice_s)
    );

    // Controller: accept operands, walk the slice across all nibbles, then hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            sum         <= '0;
            cout        <= 1'b0;
            idx         <= '0;
            carry       <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
`ifdef ADDER_SEQ_OVF_EN
            ovf         <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_r         <= a;
                        b_r         <= b;
                        carry       <= cin;
                        sum         <= '0;
                        cout        <= 1'b0;
                        idx         <= '0;
                        start_ready <= 1'b0;
                        state       <= ST_RUN;
`ifdef ADDER_SEQ_OVF_EN
                        ovf         <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= slice_s;
                    carry <= slice_co;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        cout      <= slice_co;
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
`ifdef ADDER_SEQ_OVF_EN
                        // Top result bit comes straight from the slice on this last pass
                        ovf <= (a_r[W-1] == b_r[W-1]) && (slice_s[NIBBLE_W-1] != a_r[W-1]);
`endif
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    start_ready <= 1'b1;
                    res_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - scoreboard bench for adder_seq_ctrl (NIBBLES=4)
module tb_adder_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef ADDER_SEQ_OVF_EN
    logic         ovf;
`endif

    exp_t sb[$];
    int   n_assert;
    int   n_fail;
    int   lat;
    exp_t e;
    logic [W-1:0] held_sum;
    logic         held_cout;

    adder_seq_ctrl #(.NIBBLES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
`ifdef ADDER_SEQ_OVF_EN
        .ovf         (ovf),
`endif
        .cout        (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Present operands for one cycle and queue the arithmetic reference result
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        logic [W:0] full;
        exp_t x;
        @(negedge clk);
        check("start_ready_idle", 32'(start_ready), 32'd1);
        a = ta; b = tb; cin = tc; start_valid = 1'b1;
        full = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
        x.sum  = full[W-1:0];
        x.cout = full[W];
        x.ovf  = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
        sb.push_back(x);
        @(negedge clk);
        start_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'b1;
    endtask

    // Count cycles to res_valid, then compare against the queued reference
    task automatic wait_result(input string tag);
        exp_t x;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(N));
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check({tag, "_sum"}, 32'(sum), 32'(x.sum));
            check({tag, "_cout"}, 32'(cout), 32'(x.cout));
`ifdef ADDER_SEQ_OVF_EN
            check({tag, "_ovf"}, 32'(ovf), 32'(x.ovf));
`endif
        end
    endtask

    task automatic take_result(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(start_ready), 32'd1);
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        start_op(ta, tb, tc);
        wait_result(tag);
        take_result(tag);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef ADDER_SEQ_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif

        full_op("basic", 16'h0002, 16'h0003, 1'b0);
        full_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1);
        full_op("cin_only", 16'h0000, 16'h0000, 1'b1);
        full_op("nib_carry", 16'h000F, 16'h0001, 1'b0);
        full_op("ripple3", 16'h0FFF, 16'h0001, 1'b0);
        full_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
        full_op("wrap", 16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            full_op("rand", W'($urandom), W'($urandom), 1'($urandom));
        end

        // Backpressure: result must hold while new operands are waved at the block
        start_op(16'h1111, 16'h2222, 1'b0);
        wait_result("bp");
        held_sum = sum; held_cout = cout;
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom); start_valid = 1'b1;
            @(negedge clk);
            check("bp_sum_hold", 32'(sum), 32'h3333);
            check("bp_cout_hold", 32'(cout), 32'(held_cout));
            check("bp_start_ready", 32'(start_ready), 32'd0);
            check("bp_res_valid", 32'(res_valid), 32'd1);
        end
        start_valid = 1'b0;
        take_result("bp");
        check("bp_no_accept", 32'(sb.size()), 32'd0);
        check("bp_held_sum", 32'(held_sum), 32'h3333);

        // Reset on the second RUN cycle discards the operation
        start_op(16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_start_ready", 32'(start_ready), 32'd1);
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            check("mid_rst_no_pulse", 32'(res_valid), 32'd0);
        end
        full_op("after_rst", 16'h1234, 16'h4321, 1'b0);

        // Reset and start together: nothing may be accepted
        @(negedge clk);
        rst = 1'b1; start_valid = 1'b1; a = 16'h0001; b = 16'h0001;
        @(negedge clk);
        rst = 1'b0; start_valid = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
        end
        check("rst_wins_valid", 32'(res_valid), 32'd0);
        check("rst_wins_ready", 32'(start_ready), 32'd1);

        full_op("final", 16'h8000, 16'h8000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
